// File: rtl/scara_motion_pkg.sv
// Shared encodings for the SCARA motion cell: command codes, motion-FSM state
// encodings and the command sequencer state enum.
package scara_motion_pkg;

    localparam logic [2:0] CmdMove  = 3'b000;
    localparam logic [2:0] CmdPick  = 3'b001;
    localparam logic [2:0] CmdPlace = 3'b010;
    localparam logic [2:0] CmdHome  = 3'b011;
    localparam logic [2:0] CmdStop  = 3'b100;

    localparam logic [4:0] FsmReset         = 5'b00001;
    localparam logic [4:0] FsmMvMetal       = 5'b00010;
    localparam logic [4:0] FsmPickMetal     = 5'b00011;
    localparam logic [4:0] FsmMvMould       = 5'b00100;
    localparam logic [4:0] FsmMoulding      = 5'b00101;
    localparam logic [4:0] FsmPickRubber    = 5'b01000;
    localparam logic [4:0] FsmMvCool        = 5'b01001;
    localparam logic [4:0] FsmCoolAdv       = 5'b01010;
    localparam logic [4:0] FsmCooling       = 5'b01011;
    localparam logic [4:0] FsmPickCooled    = 5'b01100;
    localparam logic [4:0] FsmMvTrim        = 5'b01101;
    localparam logic [4:0] FsmTrimAdv       = 5'b01110;
    localparam logic [4:0] FsmTrimming      = 5'b01111;
    localparam logic [4:0] FsmPickTrimmed   = 5'b10000;
    localparam logic [4:0] FsmMvPlace       = 5'b10001;
    localparam logic [4:0] FsmPlaced        = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_ISSUE,
        S_FAULT
    } seq_state_t;

    // States the motion FSM leaves on its own, without a command.
    function automatic logic is_auto_state(input logic [4:0] s);
        return (s == FsmCoolAdv) || (s == FsmTrimAdv);
    endfunction

    function automatic logic is_legal_state(input logic [4:0] s);
        case (s)
            FsmReset, FsmMvMetal, FsmPickMetal, FsmMvMould, FsmMoulding, FsmPickRubber,
            FsmMvCool, FsmCoolAdv, FsmCooling, FsmPickCooled, FsmMvTrim, FsmTrimAdv,
            FsmTrimming, FsmPickTrimmed, FsmMvPlace, FsmPlaced: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/motion_wait_timer.sv
// Saturating cycle counter with synchronous clear and count enable.
module motion_wait_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != {Width{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/motion_cmd_sequencer.sv
// Batch command sequencer driving motion_control_fsm's motion_cmd input.
// Define SEQ_TIMEOUT_EN to build the acknowledge watchdog and its timeout fault.
module motion_cmd_sequencer
    import scara_motion_pkg::*;
#(
    parameter int unsigned MOVE_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned BATCH_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic               abort,
    input  logic [4:0]         fsm_state,
    input  logic               part_present,
    input  logic               mould_done,
    input  logic               cool_done,
    input  logic               trim_done,
    output logic [2:0]         motion_cmd,
    output logic               busy,
    output logic               fault,
    output logic [BATCH_W-1:0] products_done,
    output logic               batch_done
);

    localparam int unsigned DwellW = $clog2(MOVE_CYCLES + 1);
    // The issuing cycle is the last dwell cycle, so the command registers one cycle later.
    localparam logic [DwellW-1:0] DwellLast = DwellW'(MOVE_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [4:0]         cap_q, cap_d;
    logic [BATCH_W-1:0] remaining_q, remaining_d;
    logic [BATCH_W-1:0] done_q, done_d;
    logic               batch_done_q, batch_done_d;

    logic [DwellW-1:0]  dwell_cnt;
    logic               dwell_met;
    logic               timeout;
    logic               issue;
    logic [2:0]         issue_cmd;

    motion_wait_timer #(
        .Width (DwellW)
    ) u_dwell_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q != S_EVAL),
        .enable (state_q == S_EVAL),
        .count  (dwell_cnt)
    );

    assign dwell_met = (dwell_cnt >= DwellLast);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);

    logic [WaitW-1:0] wait_cnt;
    logic             wait_active;

    assign wait_active = ((state_q == S_ISSUE) && (fsm_state == cap_q)) ||
                         ((state_q == S_EVAL) && is_auto_state(fsm_state));

    motion_wait_timer #(
        .Width (WaitW)
    ) u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (!wait_active),
        .enable (wait_active),
        .count  (wait_cnt)
    );

    assign timeout = wait_active && (wait_cnt == WaitW'(ACK_TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cap_d        = cap_q;
        remaining_d  = remaining_q;
        done_d       = done_q;
        batch_done_d = 1'b0;
        issue        = 1'b0;
        issue_cmd    = CmdStop;

        unique case (state_q)
            S_IDLE: begin
                cmd_d = CmdStop;
                if (start && !abort && (batch_size != '0)) begin
                    remaining_d = batch_size;
                    done_d      = '0;
                    state_d     = S_EVAL;
                end
            end
            S_EVAL: begin
                cmd_d = CmdStop;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    case (fsm_state)
                        FsmReset: begin
                            if (remaining_q == '0) begin
                                state_d      = S_IDLE;
                                batch_done_d = 1'b1;
                            end else if (part_present) begin
                                issue     = 1'b1;
                                issue_cmd = CmdMove;
                            end
                        end
                        FsmMvMetal: begin
                            issue     = dwell_met;
                            issue_cmd = CmdPick;
                        end
                        FsmMvMould, FsmMvCool, FsmMvTrim, FsmMvPlace: begin
                            issue     = dwell_met;
                            issue_cmd = CmdPlace;
                        end
                        FsmPickMetal, FsmPickRubber, FsmPickCooled, FsmPickTrimmed: begin
                            issue     = 1'b1;
                            issue_cmd = CmdMove;
                        end
                        FsmMoulding: begin
                            issue     = mould_done;
                            issue_cmd = CmdPick;
                        end
                        FsmCooling: begin
                            issue     = cool_done;
                            issue_cmd = CmdPick;
                        end
                        FsmTrimming: begin
                            issue     = trim_done;
                            issue_cmd = CmdPick;
                        end
                        FsmCoolAdv, FsmTrimAdv: begin
                            issue = 1'b0;
                        end
                        FsmPlaced: begin
                            if (remaining_q == '0) begin
                                issue     = 1'b1;
                                issue_cmd = CmdHome;
                            end else if (part_present) begin
                                issue     = 1'b1;
                                issue_cmd = CmdMove;
                            end
                        end
                        default: state_d = S_FAULT;
                    endcase
                    if (issue) begin
                        cmd_d   = issue_cmd;
                        cap_d   = fsm_state;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    cmd_d   = CmdStop;
                    state_d = S_IDLE;
                end else if (fsm_state != cap_q) begin
                    cmd_d   = CmdStop;
                    state_d = is_legal_state(fsm_state) ? S_EVAL : S_FAULT;
                    if ((fsm_state == FsmPlaced) && (remaining_q != '0)) begin
                        done_d      = done_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            S_FAULT: begin
                cmd_d = CmdStop;
            end
        endcase

        if (timeout && !abort) begin
            cmd_d   = CmdStop;
            state_d = S_FAULT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= CmdStop;
            cap_q        <= '0;
            remaining_q  <= '0;
            done_q       <= '0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cap_q        <= cap_d;
            remaining_q  <= remaining_d;
            done_q       <= done_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign motion_cmd    = cmd_q;
    assign busy          = (state_q == S_EVAL) || (state_q == S_ISSUE);
    assign fault         = (state_q == S_FAULT);
    assign products_done = done_q;
    assign batch_done    = batch_done_q;

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Self-checking bench for motion_cmd_sequencer with a randomised motion-FSM/plant model.
// Watchdog expectations follow SEQ_TIMEOUT_EN.
module tb_motion_cmd_sequencer;

    localparam logic [2:0] C_MOVE  = 3'b000;
    localparam logic [2:0] C_PICK  = 3'b001;
    localparam logic [2:0] C_PLACE = 3'b010;
    localparam logic [2:0] C_HOME  = 3'b011;
    localparam logic [2:0] C_STOP  = 3'b100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] batch_size = 8'd0;
    logic       abort = 1'b0;
    logic [4:0] fsm_state;
    logic       part_present, mould_done, cool_done, trim_done;
    logic [2:0] motion_cmd;
    logic       busy, fault, batch_done;
    logic [7:0] products_done;

    int checks = 0;
    int errors = 0;

    // Plant / motion FSM model controls
    logic       plant_auto = 1'b0;
    logic       man_part = 1'b0, man_mould = 1'b0, man_cool = 1'b0, man_trim = 1'b0;
    logic       m_freeze = 1'b0;
    logic       ovr_en = 1'b0;
    logic [4:0] ovr_val = 5'd0;
    logic [4:0] m_state, m_nx;
    int         m_cnt, m_lat, st_cnt, st_dly;

    logic [2:0] cmd_log[$];
    int         bd_pulses = 0;
    logic [2:0] prev_cmd = C_STOP;
    logic [2:0] product_seq[13];

    always #5 clock = ~clock;

    motion_cmd_sequencer #(
        .MOVE_CYCLES (16),
        .ACK_TIMEOUT (64),
        .BATCH_W     (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .batch_size    (batch_size),
        .abort         (abort),
        .fsm_state     (fsm_state),
        .part_present  (part_present),
        .mould_done    (mould_done),
        .cool_done     (cool_done),
        .trim_done     (trim_done),
        .motion_cmd    (motion_cmd),
        .busy          (busy),
        .fault         (fault),
        .products_done (products_done),
        .batch_done    (batch_done)
    );

    // Transition table of the motion FSM: 0 means the command is not accepted.
    function automatic logic [4:0] model_next(input logic [4:0] s, input logic [2:0] c,
                                              input logic md, input logic cd, input logic td);
        logic [7:0] k;
        k = {s, c};
        if (s == 5'b01010) return 5'b01011;
        if (s == 5'b01110) return 5'b01111;
        case (k)
            {5'b00001, C_MOVE}:  return 5'b00010;
            {5'b10010, C_MOVE}:  return 5'b00010;
            {5'b10010, C_HOME}:  return 5'b00001;
            {5'b00010, C_PICK}:  return 5'b00011;
            {5'b00011, C_MOVE}:  return 5'b00100;
            {5'b00100, C_PLACE}: return 5'b00101;
            {5'b00101, C_PICK}:  return md ? 5'b01000 : 5'b00000;
            {5'b01000, C_MOVE}:  return 5'b01001;
            {5'b01001, C_PLACE}: return 5'b01010;
            {5'b01011, C_PICK}:  return cd ? 5'b01100 : 5'b00000;
            {5'b01100, C_MOVE}:  return 5'b01101;
            {5'b01101, C_PLACE}: return 5'b01110;
            {5'b01111, C_PICK}:  return td ? 5'b10000 : 5'b00000;
            {5'b10000, C_MOVE}:  return 5'b10001;
            {5'b10001, C_PLACE}: return 5'b10010;
            default:             return 5'b00000;
        endcase
    endfunction

    assign m_nx         = model_next(m_state, motion_cmd, mould_done, cool_done, trim_done);
    assign fsm_state    = ovr_en ? ovr_val : m_state;
    assign part_present = plant_auto ? (st_cnt >= st_dly) : man_part;
    assign mould_done   = plant_auto ? (st_cnt >= st_dly) : man_mould;
    assign cool_done    = plant_auto ? (st_cnt >= st_dly) : man_cool;
    assign trim_done    = plant_auto ? (st_cnt >= st_dly) : man_trim;

    // Accepts a command after it has been held for m_lat (>=2) cycles.
    always @(posedge clock) begin
        if (reset) begin
            m_state <= 5'b00001;
            m_cnt   <= 0;
            m_lat   <= 2;
            st_cnt  <= 0;
            st_dly  <= 0;
        end else if (!m_freeze) begin
            if ((m_nx != 5'd0) && (m_cnt + 1 >= m_lat)) begin
                m_state <= m_nx;
                m_cnt   <= 0;
                m_lat   <= int'($urandom_range(2, 5));
                st_cnt  <= 0;
                st_dly  <= int'($urandom_range(0, 8));
            end else begin
                m_cnt  <= (m_nx != 5'd0) ? m_cnt + 1 : 0;
                st_cnt <= st_cnt + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && (motion_cmd != C_STOP) && (prev_cmd == C_STOP)) cmd_log.push_back(motion_cmd);
        if (!reset && batch_done) bd_pulses++;
        prev_cmd = motion_cmd;
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; ovr_en = 1'b0; m_freeze = 1'b0;
        plant_auto = 1'b0; man_part = 1'b1; man_mould = 1'b1; man_cool = 1'b1; man_trim = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_start(input logic [7:0] n);
        batch_size = n;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (motion_cmd !== C_STOP) begin errors++; $display("FAIL reset_cmd got %b want %b", motion_cmd, C_STOP); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
        checks++; if (products_done !== 8'd0) begin errors++; $display("FAIL reset_products got %0d want 0", products_done); end
        checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL reset_batch_done got %b want 0", batch_done); end
        reset = 1'b0;
    endtask

    task automatic test_start_filter();
        do_reset();
        pulse_start(8'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_zero busy got %b want 0", busy); end
        batch_size = 8'd3; start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort busy got %b want 0", busy); end
    endtask

    task automatic test_start_latency();
        do_reset();
        pulse_start(8'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy got %b want 1", busy); end
        checks++; if (motion_cmd !== C_STOP) begin errors++; $display("FAIL latency_t1 got %b want %b", motion_cmd, C_STOP); end
        @(negedge clock);
        checks++; if (motion_cmd !== C_MOVE) begin errors++; $display("FAIL latency_t2 got %b want %b", motion_cmd, C_MOVE); end
    endtask

    task automatic test_full_batch(input int n);
        logic [2:0] exp_q[$];
        int base_log, base_bd, cyc, bad;
        do_reset();
        plant_auto = 1'b1;
        for (int p = 0; p < n; p++) for (int i = 0; i < 13; i++) exp_q.push_back(product_seq[i]);
        exp_q.push_back(C_HOME);
        base_log = cmd_log.size();
        base_bd  = bd_pulses;
        pulse_start(8'(n));
        cyc = 0;
        while (busy && cyc < 8000) begin @(negedge clock); cyc++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_done n=%0d busy still %b after %0d cycles", n, busy, cyc); end
        repeat (3) @(negedge clock);
        checks++; if (products_done !== 8'(n)) begin errors++; $display("FAIL full_products got %0d want %0d", products_done, n); end
        checks++; if (bd_pulses - base_bd != 1) begin errors++; $display("FAIL full_batch_done pulses got %0d want 1", bd_pulses - base_bd); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL full_fault got %b want 0", fault); end
        checks++; if (cmd_log.size() - base_log != exp_q.size()) begin
            errors++; $display("FAIL full_cmd_count got %0d want %0d", cmd_log.size() - base_log, exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && base_log + i < cmd_log.size(); i++)
            if (bad < 0 && cmd_log[base_log + i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin
            errors++; $display("FAIL full_cmd_order idx %0d got %b want %b", bad, cmd_log[base_log + bad], exp_q[bad]);
        end
    endtask

    task automatic test_dwell();
        int cyc;
        do_reset();
        pulse_start(8'd1);
        cyc = 0;
        while (fsm_state !== 5'b00010 && cyc < 50) begin @(negedge clock); cyc++; end
        checks++; if (fsm_state !== 5'b00010) begin errors++; $display("FAIL dwell_enter got %b want 00010", fsm_state); end
        cyc = 0;
        while (motion_cmd !== C_PICK && cyc < 100) begin @(negedge clock); cyc++; end
        checks++; if (cyc != 17) begin errors++; $display("FAIL dwell_pick_delay got %0d want 17", cyc); end
    endtask

    task automatic wait_moulding(input string tag);
        int cyc;
        cyc = 0;
        while (fsm_state !== 5'b00101 && cyc < 300) begin @(negedge clock); cyc++; end
        checks++; if (fsm_state !== 5'b00101) begin errors++; $display("FAIL %s_reach got %b want 00101", tag, fsm_state); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_mould_wait();
        int viol;
        do_reset();
        man_mould = 1'b0;
        pulse_start(8'd1);
        wait_moulding("mould");
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (motion_cmd !== C_STOP || fault !== 1'b0) viol++;
            @(negedge clock);
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL mould_hold got %0d bad cycles want 0", viol); end
        man_mould = 1'b1;
        @(negedge clock);
        checks++; if (motion_cmd !== C_PICK) begin errors++; $display("FAIL mould_pick got %b want %b", motion_cmd, C_PICK); end
    endtask

    task automatic test_illegal();
        do_reset();
        man_mould = 1'b0;
        pulse_start(8'd1);
        wait_moulding("illegal");
        ovr_val = 5'b00110; ovr_en = 1'b1;
        @(negedge clock);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault got %b want 1", fault); end
        checks++; if (motion_cmd !== C_STOP) begin errors++; $display("FAIL illegal_cmd got %b want %b", motion_cmd, C_STOP); end
        abort = 1'b1; ovr_en = 1'b0;
        @(negedge clock);
        abort = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (fault !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL illegal_sticky got fault %b busy %b want 1 0", fault, busy);
        end
        do_reset();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL illegal_reset got %b want 0", fault); end
    endtask

    task automatic test_watchdog();
        int cyc;
        do_reset();
        m_freeze = 1'b1;
        pulse_start(8'd1);
        cyc = 0;
        while (motion_cmd !== C_MOVE && cyc < 20) begin @(negedge clock); cyc++; end
        checks++; if (motion_cmd !== C_MOVE) begin errors++; $display("FAIL wd_move got %b want %b", motion_cmd, C_MOVE); end
        repeat (64) @(negedge clock);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", fault); end
        @(negedge clock);
`ifdef SEQ_TIMEOUT_EN
        checks++; if (fault !== 1'b1 || motion_cmd !== C_STOP) begin
            errors++; $display("FAIL wd_trip got fault %b cmd %b want 1 %b", fault, motion_cmd, C_STOP);
        end
        repeat (20) @(negedge clock);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wd_held got %b want 1", fault); end
`else
        repeat (40) @(negedge clock);
        checks++; if (fault !== 1'b0 || motion_cmd !== C_MOVE) begin
            errors++; $display("FAIL wd_off got fault %b cmd %b want 0 %b", fault, motion_cmd, C_MOVE);
        end
`endif
    endtask

    task automatic test_abort_restart();
        int cyc;
        do_reset();
        pulse_start(8'd2);
        cyc = 0;
        while (products_done !== 8'd1 && cyc < 2000) begin @(negedge clock); cyc++; end
        checks++; if (products_done !== 8'd1) begin errors++; $display("FAIL abort_first got %0d want 1", products_done); end
        man_part = 1'b0;
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || motion_cmd !== C_STOP || products_done !== 8'd1) begin
            errors++; $display("FAIL abort_state got busy %b cmd %b prod %0d want 0 %b 1", busy, motion_cmd, products_done, C_STOP);
        end
        man_part = 1'b1;
        pulse_start(8'd2);
        checks++; if (products_done !== 8'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart got prod %0d busy %b want 0 1", products_done, busy);
        end
        cyc = 0;
        while (busy && cyc < 4000) begin @(negedge clock); cyc++; end
        checks++; if (busy !== 1'b0 || products_done !== 8'd2) begin
            errors++; $display("FAIL restart_done got busy %b prod %0d want 0 2", busy, products_done);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        pulse_start(8'd3);
        cyc = 0;
        while (products_done !== 8'd1 && cyc < 2000) begin @(negedge clock); cyc++; end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (motion_cmd !== C_STOP || busy !== 1'b0 || products_done !== 8'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL reset_mid got cmd %b busy %b prod %0d fault %b want %b 0 0 0",
                               motion_cmd, busy, products_done, fault, C_STOP);
        end
        reset = 1'b0;
    endtask

    initial begin
        product_seq = '{C_MOVE, C_PICK, C_MOVE, C_PLACE, C_PICK, C_MOVE, C_PLACE,
                        C_PICK, C_MOVE, C_PLACE, C_PICK, C_MOVE, C_PLACE};
        test_reset();
        test_start_filter();
        test_start_latency();
        test_full_batch(1);
        for (int r = 0; r < 3; r++) test_full_batch(int'($urandom_range(1, 3)));
        test_dwell();
        test_mould_wait();
        test_illegal();
        test_watchdog();
        test_abort_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motion_cmd_sequencer.md
# motion_cmd_sequencer

- Upstream command source for `motion_control_fsm`; drives its `motion_cmd` input.
- Watches the FSM's registered `state` output, plant sensors and travel dwell timers, then issues each MOVE/PICK/PLACE/HOME in legal order.
- Runs a batch of N products and counts them.
- A watchdog faults the cell when the FSM does not acknowledge a command.

## Interface
- `MOVE_CYCLES`, default 16: minimum dwell in a move state before PICK/PLACE is issued.
- `ACK_TIMEOUT`, default 64: max cycles waiting for a state change (ack, or an auto-advance state).
- `BATCH_W`, default 8: width of batch size and product counter.
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse; begins a batch of `batch_size` products (ignored unless idle).
- `batch_size` in BATCH_W: products per batch; sampled on `start`.
- `abort` in 1: return to idle and drive STOP.
- `fsm_state` in 5: registered `state` output of `motion_control_fsm`.
- `part_present` in 1: blank available on conveyor 1.
- `mould_done`, `cool_done`, `trim_done` in 1 each: station process complete, level.
- `motion_cmd` out 3: registered command to the motion FSM.
- `busy` out 1: batch in progress.
- `fault` out 1: sticky watchdog or illegal-state fault.
- `products_done` out BATCH_W: products placed in the current batch.
- `batch_done` out 1: one-cycle pulse when the batch ends at home.

## Operation
- Command codes: MOVE 000, PICK 001, PLACE 010, HOME 011, STOP 100.
- STOP is the idle code. The motion FSM accepts it in no state.
- Sequencer states: S_IDLE, S_EVAL, S_ISSUE, S_FAULT.
- **S_IDLE:** cmd STOP, busy 0.
  - `start` with `batch_size`≠0: latch remaining=batch_size, clear products_done, go to S_EVAL.
  - `start` with `batch_size`=0: ignored.
- **S_EVAL:** chooses a command from `fsm_state`. When the condition holds, latch cmd, capture `fsm_state`, go to S_ISSUE.
  - 00001 reset: remaining>0 and part_present → MOVE. remaining=0 → S_IDLE, pulse batch_done.
  - Move states 00010, 00100, 01001, 01101, 10001: dwell≥MOVE_CYCLES → PICK (00010) or PLACE (all others).
  - 00011 picking_metal, 01000 picking_rubber, 01100 picking_cooled_metal, 10000 picking_trimmed → MOVE.
  - 00101 + mould_done → PICK. 01011 + cool_done → PICK. 01111 + trim_done → PICK.
  - 01010 and 01110 (auto-advance): issue nothing; wait for the state to change.
  - 10010 placed: remaining>0 and part_present → MOVE; remaining=0 → HOME.
  - Any other encoding → S_FAULT.
- Dwell counter: cleared on every entry to S_EVAL; increments each S_EVAL cycle; saturates.
- **S_ISSUE:** hold cmd until `fsm_state` ≠ captured value, then go to S_EVAL.
  - cmd returns to STOP in the cycle after the change is detected.
  - If the new state is 10010: products_done+1, remaining−1, in the same cycle.
- **S_FAULT:** cmd STOP, fault=1, busy=0. Only `reset` exits.
- `abort` in S_EVAL/S_ISSUE: next cycle S_IDLE, STOP, counters kept. `abort` has no effect in S_FAULT.
- `abort` and `start` in the same cycle: abort wins.

## Timing
- Reset values: motion_cmd=100, busy=0, fault=0, products_done=0, batch_done=0, state S_IDLE.
- `start` at cycle T → S_EVAL at T+1 → earliest MOVE on motion_cmd at T+2.
- Motion FSM ack latency: `fsm_state` changes ≥2 cycles after the command appears. Expected hold is ≥2 cycles.
- Wait counter counts S_ISSUE cycles and auto-advance S_EVAL cycles. At count=ACK_TIMEOUT → S_FAULT next cycle.
- `reset` mid-batch: all outputs return to reset values on the next edge.

## Configuration
- `SEQ_TIMEOUT_EN` defined: watchdog wait counter and timeout fault are built.
- `SEQ_TIMEOUT_EN` undefined: no wait counter and no timeout. `fault` is set only by an illegal `fsm_state`.

## Structure
- Package `scara_motion_pkg` holds: command codes, 5-bit motion-FSM state encodings, sequencer state enum.
- Sub-module `motion_wait_timer` is a clear/enable saturating counter. It is instantiated twice: once for dwell, once for the watchdog.

## Test plan
- Full product, batch_size=1, sensors ready, FSM model attached:
  - command order MOVE,PICK,MOVE,PLACE,PICK,MOVE,PLACE,PICK,MOVE,PLACE,PICK,MOVE,PLACE,HOME.
  - products_done=1, one batch_done pulse.
- Dwell, MOVE_CYCLES=16: FSM enters 00010 → PICK first appears exactly 17 cycles later (16 dwell cycles, then the registered output).
- mould_done held 0 for 100 cycles in 00101 → motion_cmd stays 100, no fault. Raise it → PICK.
- Watchdog, ACK_TIMEOUT=64, FSM model frozen after MOVE → fault=1, cmd=100 at cycle 65 of S_ISSUE. Held until reset.
- batch_size=2, abort after the first placed → products_done=1, busy=0, cmd=100. A later start with batch_size=2 → products_done=0, batch restarts.
- fsm_state forced to 00110 while busy → fault=1 and STOP on the next cycle.
